// File: rtl/lcd_text_refresh.sv
// lcd_text_refresh
//   HD44780-class character-LCD driver with an internal ROWS x COLS text buffer.
//   After reset it waits POWERUP_CYC cycles, sends the init commands, then repaints the
//   whole panel (row address command followed by COLS characters, per row) every time
//   the buffer has been written since the last repaint started.
// Ports
//   iCLK, iRESET          clock, asynchronous active-high reset
//   iWR_EN/ADDR/DATA      host buffer write (linear index row*COLS+col, ASCII byte)
//   oBUSY                 high whenever the controller is not idle
//   oINIT_DONE            sticky flag, set once the init sequence has been sent
//   LCD_RS/RW/E/DATA      LCD pins (RW is always 0, write-only)
module lcd_text_refresh #(
  parameter int unsigned ROWS           = 2,
  parameter int unsigned COLS           = 16,
  parameter int unsigned POWERUP_CYC    = 750000,
  parameter int unsigned E_HIGH_CYC     = 25,
  parameter int unsigned CMD_WAIT_CYC   = 2500,
  parameter int unsigned CLEAR_WAIT_CYC = 100000,
  // Address width; may be widened beyond the minimum so out-of-range indices exist.
  parameter int unsigned AW             = $clog2(ROWS * COLS)
) (
  input  logic          iCLK,
  input  logic          iRESET,
  input  logic          iWR_EN,
  input  logic [AW-1:0] iWR_ADDR,
  input  logic [7:0]    iWR_DATA,
  output logic          oBUSY,
  output logic          oINIT_DONE,
  output logic          LCD_RS,
  output logic          LCD_RW,
  output logic          LCD_E,
  output logic [7:0]    LCD_DATA
);

  localparam int unsigned NB   = ROWS * COLS;
  localparam int unsigned IW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned RW   = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned CW   = $clog2(COLS);
  localparam int unsigned TM0  = (POWERUP_CYC > E_HIGH_CYC) ? POWERUP_CYC : E_HIGH_CYC;
  localparam int unsigned TM1  = (CMD_WAIT_CYC > CLEAR_WAIT_CYC) ? CMD_WAIT_CYC
                                                                  : CLEAR_WAIT_CYC;
  localparam int unsigned TMAX = (TM0 > TM1) ? TM0 : TM1;
  localparam int unsigned TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {StPowerup, StInit, StIdle, StRowAddr, StChars} state_e;
  typedef enum logic [1:0] {PhSetup, PhEHigh, PhWait} phase_e;

  state_e          r_state;
  phase_e          r_phase;
  logic [TW-1:0]   r_timer;
  logic [1:0]      r_idx;
  logic [RW-1:0]   r_row;
  logic [CW-1:0]   r_col;
  logic [IW-1:0]   r_ptr;
  logic            r_dirty;
  logic            r_clear;
  logic            r_e;
  logic            r_rs;
  logic [7:0]      r_data;
  logic            r_busy;
  logic            r_init_done;
  logic [7:0]      r_buf [NB];

  logic            w_wr_ok;
  logic [IW-1:0]   w_wr_idx;
  logic [TW-1:0]   w_wait_last;
  logic [7:0]      w_next_init;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return (ROWS == 1) ? 8'h30 : 8'h38;
      2'd1:    return 8'h0C;
      2'd2:    return 8'h01;
      default: return 8'h06;
    endcase
  endfunction

  // Set-DDRAM-address command for the start of a row.
  function automatic logic [7:0] row_cmd(input logic [RW-1:0] r);
    case (int'(r))
      0:       return 8'h80;
      1:       return 8'hC0;
      2:       return 8'h80 | 8'(COLS);
      default: return 8'h80 | (8'h40 + 8'(COLS));
    endcase
  endfunction

  assign w_wr_ok     = iWR_EN && (32'(iWR_ADDR) < NB);
  assign w_wr_idx    = IW'(iWR_ADDR);
  // The clear command needs a much longer settle time than any other byte.
  assign w_wait_last = r_clear ? TW'(CLEAR_WAIT_CYC - 1) : TW'(CMD_WAIT_CYC - 1);
  assign w_next_init = init_cmd(r_idx + 2'd1);

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      for (int i = 0; i < int'(NB); i++) r_buf[i] <= 8'h20;
    end else if (w_wr_ok) begin
      r_buf[w_wr_idx] <= iWR_DATA;
    end
  end

  always_ff @(posedge iCLK or posedge iRESET) begin
    if (iRESET) begin
      r_state     <= StPowerup;
      r_phase     <= PhSetup;
      r_timer     <= '0;
      r_idx       <= '0;
      r_row       <= '0;
      r_col       <= '0;
      r_ptr       <= '0;
      r_dirty     <= 1'b1;
      r_clear     <= 1'b0;
      r_e         <= 1'b0;
      r_rs        <= 1'b0;
      r_data      <= 8'h00;
      r_busy      <= 1'b1;
      r_init_done <= 1'b0;
    end else begin
      case (r_state)
        StPowerup: begin
          if (r_timer == TW'(POWERUP_CYC - 1)) begin
            r_state <= StInit;
            r_idx   <= '0;
            r_phase <= PhSetup;
            r_timer <= '0;
            r_rs    <= 1'b0;
            r_data  <= init_cmd(2'd0);
            r_clear <= 1'b0;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        StIdle: begin
          if (r_dirty) begin
            r_dirty <= 1'b0;
            r_state <= StRowAddr;
            r_row   <= '0;
            r_col   <= '0;
            r_ptr   <= '0;
            r_busy  <= 1'b1;
            r_phase <= PhSetup;
            r_timer <= '0;
            r_rs    <= 1'b0;
            r_data  <= row_cmd('0);
            r_clear <= 1'b0;
          end
        end
        default: begin
          // Byte engine shared by StInit, StRowAddr and StChars. RS/DATA are loaded on
          // the edge that enters PhSetup and held until the next byte is loaded.
          case (r_phase)
            PhSetup: begin
              r_e     <= 1'b1;
              r_phase <= PhEHigh;
              r_timer <= '0;
            end
            PhEHigh: begin
              if (r_timer == TW'(E_HIGH_CYC - 1)) begin
                r_e     <= 1'b0;
                r_phase <= PhWait;
                r_timer <= '0;
              end else begin
                r_timer <= r_timer + 1'b1;
              end
            end
            default: begin
              if (r_timer == w_wait_last) begin
                r_timer <= '0;
                r_phase <= PhSetup;
                case (r_state)
                  StInit: begin
                    if (r_idx == 2'd3) begin
                      r_init_done <= 1'b1;
                      r_busy      <= 1'b0;
                      r_state     <= StIdle;
                    end else begin
                      r_idx   <= r_idx + 2'd1;
                      r_rs    <= 1'b0;
                      r_data  <= w_next_init;
                      r_clear <= (w_next_init == 8'h01);
                    end
                  end
                  StRowAddr: begin
                    r_state <= StChars;
                    r_col   <= '0;
                    r_rs    <= 1'b1;
                    r_data  <= r_buf[r_ptr];
                    r_ptr   <= r_ptr + 1'b1;
                    r_clear <= 1'b0;
                  end
                  default: begin
                    if (r_col == CW'(COLS - 1)) begin
                      if (r_row == RW'(ROWS - 1)) begin
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                      end else begin
                        r_row   <= r_row + 1'b1;
                        r_state <= StRowAddr;
                        r_rs    <= 1'b0;
                        r_data  <= row_cmd(r_row + 1'b1);
                      end
                    end else begin
                      r_col  <= r_col + 1'b1;
                      r_rs   <= 1'b1;
                      r_data <= r_buf[r_ptr];
                      r_ptr  <= r_ptr + 1'b1;
                    end
                  end
                endcase
              end else begin
                r_timer <= r_timer + 1'b1;
              end
            end
          endcase
        end
      endcase
      // A write always wins over the clear issued when a repaint is launched.
      if (w_wr_ok) r_dirty <= 1'b1;
    end
  end

  assign oBUSY      = r_busy;
  assign oINIT_DONE = r_init_done;
  assign LCD_RS     = r_rs;
  assign LCD_RW     = 1'b0;
  assign LCD_E      = r_e;
  assign LCD_DATA   = r_data;

endmodule

// File: tb/tb_lcd_text_refresh.sv
module tb_lcd_text_refresh;

  localparam int unsigned AW = 4;
  localparam int EH = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [7:0]    wr_data = '0;
  logic          busy, init_done, lcd_rs, lcd_rw, lcd_e;
  logic [7:0]    lcd_data;

  int n_total = 0;
  int n_pass = 0;
  int n_fail = 0;
  int cyc = 0;

  logic [8:0] cap [$];
  int         cap_t [$];
  logic [7:0] mbuf [8];
  logic [8:0] init_exp [4] = '{9'h038, 9'h00C, 9'h001, 9'h006};
  int         init_gap [4] = '{21, 6, 6, 13};

  lcd_text_refresh #(
    .ROWS(2), .COLS(4), .POWERUP_CYC(20), .E_HIGH_CYC(2), .CMD_WAIT_CYC(3),
    .CLEAR_WAIT_CYC(10), .AW(AW)
  ) dut (
    .iCLK(clk), .iRESET(rst), .iWR_EN(wr_en), .iWR_ADDR(wr_addr), .iWR_DATA(wr_data),
    .oBUSY(busy), .oINIT_DONE(init_done), .LCD_RS(lcd_rs), .LCD_RW(lcd_rw),
    .LCD_E(lcd_e), .LCD_DATA(lcd_data)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Byte monitor: records each E pulse, checks pulse width, bus stability and RW.
  initial begin : monitor
    logic       e_q;
    logic [8:0] cur;
    int         hi;
    e_q = 1'b0;
    cur = '0;
    hi  = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        e_q = 1'b0;
        hi  = 0;
      end else begin
        if (lcd_e === 1'b1 && e_q !== 1'b1) begin
          cap.push_back({lcd_rs, lcd_data});
          cap_t.push_back(cyc);
          cur = {lcd_rs, lcd_data};
          hi  = 1;
          check("rw_low", 32'(lcd_rw), 32'd0);
        end else if (lcd_e === 1'b1) begin
          hi++;
          check("bus_stable_e_high", 32'({lcd_rs, lcd_data}), 32'(cur));
        end else if (e_q === 1'b1) begin
          check("e_high_len", hi, EH);
        end
        e_q = lcd_e;
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic wait_bytes(input int n, input string tag);
    int k = 0;
    while (cap.size() < n && k < 3000) begin
      step();
      k++;
    end
    check(tag, cap.size(), n);
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy !== 1'b0 && k < 3000) begin
      step();
      k++;
    end
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic wr(input int a, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_data = d;
    step();
    wr_en   = 1'b0;
  endtask

  // Expected byte k of a 2x4 repaint from the bench's buffer model.
  function automatic logic [8:0] exp_byte(input int k);
    if (k == 0) return 9'h080;
    if (k == 5) return 9'h0C0;
    if (k < 5) return {1'b1, mbuf[k-1]};
    return {1'b1, mbuf[k-2]};
  endfunction

  task automatic check_pass(input int b, input string tag);
    for (int k = 0; k < 10; k++)
      check($sformatf("%s_byte%0d", tag, k), 32'(cap[b+k]), 32'(exp_byte(k)));
  endtask

  task automatic check_init(input int b, input int t0, input string tag);
    for (int k = 0; k < 4; k++) begin
      check($sformatf("%s_cmd%0d", tag, k), 32'(cap[b+k]), 32'(init_exp[k]));
      if (k == 0) check($sformatf("%s_t%0d", tag, k), cap_t[b] - t0, init_gap[0]);
      else check($sformatf("%s_t%0d", tag, k), cap_t[b+k] - cap_t[b+k-1], init_gap[k]);
    end
    // Last init byte, one idle cycle, then the first row-address byte.
    check({tag, "_to_repaint"}, cap_t[b+4] - cap_t[b+3], 7);
  endtask

  initial begin
    int t0;
    int tw;
    int b;
    logic saw;
    for (int i = 0; i < 8; i++) mbuf[i] = 8'h20;

    // 1: reset state, power-up delay, init sequence, first repaint of spaces
    repeat (3) step();
    check("rst_e", 32'(lcd_e), 32'd0);
    check("rst_rs", 32'(lcd_rs), 32'd0);
    check("rst_rw", 32'(lcd_rw), 32'd0);
    check("rst_data", 32'(lcd_data), 32'h00);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_init_done", 32'(init_done), 32'd0);
    t0  = cyc;
    rst = 1'b0;
    wait_bytes(14, "t1_bytes");
    check_init(0, t0, "t1_init");
    check_pass(4, "t1_pass");
    wait_idle("t1_idle");
    check("t1_init_done", 32'(init_done), 32'd1);
    repeat (10) step();
    check("t1_no_extra", cap.size(), 14);

    // 2: single write while idle
    tw = cyc;
    wr(5, 8'h41);
    mbuf[5] = 8'h41;
    wait_bytes(24, "t2_bytes");
    wait_idle("t2_idle");
    check("t2_start", cap_t[14] - tw, 3);
    check("t2_busy_end", cyc - tw, 62);
    check_pass(14, "t2_pass");

    // 3: write lands while row 1 is streaming
    b = cap.size();
    wr(0, 8'h42);
    mbuf[0] = 8'h42;
    wait_bytes(b + 7, "t3_row1");
    wr(2, 8'h5A);
    wait_bytes(b + 10, "t3_first");
    check_pass(b, "t3_first");
    mbuf[2] = 8'h5A;
    wait_bytes(b + 20, "t3_second");
    check_pass(b + 10, "t3_second");
    wait_idle("t3_idle");
    repeat (10) step();
    check("t3_count", cap.size(), b + 20);

    // 4: out-of-range write is ignored
    b = cap.size();
    saw = 1'b0;
    wr(8, 8'h55);
    for (int i = 0; i < 30; i++) begin
      if (busy !== 1'b0) saw = 1'b1;
      step();
    end
    check("t4_busy_seen", 32'(saw), 32'd0);
    check("t4_count", cap.size(), b);

    // 5: second write coincides with the idle edge that launches the repaint
    b = cap.size();
    check("t5_idle_before", 32'(busy), 32'd0);
    wr_en   = 1'b1;
    wr_addr = AW'(1);
    wr_data = 8'h31;
    step();
    wr_addr = AW'(6);
    wr_data = 8'h37;
    step();
    wr_en   = 1'b0;
    mbuf[1] = 8'h31;
    mbuf[6] = 8'h37;
    wait_bytes(b + 20, "t5_bytes");
    check_pass(b, "t5_first");
    check_pass(b + 10, "t5_second");
    check("t5_back_to_back", cap_t[b+10] - cap_t[b+9], 7);
    wait_idle("t5_idle");
    repeat (10) step();
    check("t5_count", cap.size(), b + 20);

    // 6: reset while E is high during character output
    b = cap.size();
    wr(3, 8'h44);
    wait_bytes(b + 3, "t6_mid");
    check("t6_e_before", 32'(lcd_e), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("t6_e_async", 32'(lcd_e), 32'd0);
    check("t6_busy", 32'(busy), 32'd1);
    check("t6_init_done", 32'(init_done), 32'd0);
    check("t6_rs", 32'(lcd_rs), 32'd0);
    check("t6_data", 32'(lcd_data), 32'h00);
    step();
    for (int i = 0; i < 8; i++) mbuf[i] = 8'h20;
    t0  = cyc;
    rst = 1'b0;
    b   = b + 3;
    wait_bytes(b + 14, "t6_bytes");
    check_init(b, t0, "t6_init");
    check_pass(b + 4, "t6_pass");
    wait_idle("t6_idle");
    check("t6_init_done_again", 32'(init_done), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
